// File: rtl/gauss_pkg.sv
// Shared constants and FSM state type for the gauss_2 window front end.
package gauss_pkg;

  localparam int unsigned IMG_W_DEF     = 320;
  localparam int unsigned IMG_H_DEF     = 240;
  localparam int unsigned PIX_W_DEF     = 8;
  localparam int unsigned WIN_N         = 9;
  localparam int unsigned WIN_PER_FRAME = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);
  localparam int unsigned CNT_W         = 17;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/gauss_line_buf.sv
// One image row of pixel storage, single address, read-before-write.
module gauss_line_buf #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_c_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Combinational read returns the value stored before this cycle's write.
  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/gauss_window_gen.sv
// Streaming 3x3 window generator for the gauss_2 core.
// Optional build macro GAUSS_WIN_CNT_EN adds the per-frame window counter win_cnt_o.
module gauss_window_gen
  import gauss_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PIX_W-1:0]       pix_i,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  output logic [WIN_N*PIX_W-1:0] win_o,
  output logic                   win_valid_o,
  input  logic                   win_ready_i,
  output logic                   win_last_o
`ifdef GAUSS_WIN_CNT_EN
  ,
  output logic [CNT_W-1:0]       win_cnt_o
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned WIN_W = WIN_N * PIX_W;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  logic               pix_acc_c;
  logic               win_acc_c;
  logic               produce_c;
  logic               row_end_c;
  logic               frame_end_c;
  logic [PIX_W-1:0]   lb0_rd_c;
  logic [PIX_W-1:0]   lb1_rd_c;

  assign pix_ready_o = !valid_q | win_ready_i;
  assign pix_acc_c   = pix_valid_i & pix_ready_o;
  assign win_acc_c   = valid_q & win_ready_i;
  assign row_end_c   = (col_q == COL_W'(IMG_W - 1));
  assign frame_end_c = row_end_c && (row_q == ROW_W'(IMG_H - 1));
  // RUN implies row >= 2, so only the column bound is left to test.
  assign produce_c   = (state_q == RUN) && (col_q >= COL_W'(2));

  gauss_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk_i     (clk_i),
    .we_i      (pix_acc_c),
    .addr_i    (col_q),
    .wdata_i   (pix_i),
    .rdata_c_o (lb0_rd_c)
  );

  gauss_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk_i     (clk_i),
    .we_i      (pix_acc_c),
    .addr_i    (col_q),
    .wdata_i   (lb0_rd_c),
    .rdata_c_o (lb1_rd_c)
  );

  // Next-state: raster counters, window shift, output handshake and FSM.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (pix_acc_c) begin
      col_d = row_end_c ? '0 : col_q + COL_W'(1);
      if (row_end_c) row_d = frame_end_c ? '0 : row_q + ROW_W'(1);
      for (int j = 0; j < 3; j++) begin
        win_d[(3*j)*PIX_W   +: PIX_W] = win_q[(3*j+1)*PIX_W +: PIX_W];
        win_d[(3*j+1)*PIX_W +: PIX_W] = win_q[(3*j+2)*PIX_W +: PIX_W];
      end
      win_d[2*PIX_W +: PIX_W] = lb1_rd_c;
      win_d[5*PIX_W +: PIX_W] = lb0_rd_c;
      win_d[8*PIX_W +: PIX_W] = pix_i;
      valid_d = produce_c;
      last_d  = produce_c & frame_end_c;
      case (state_q)
        FILL:    if (row_q == ROW_W'(2)) state_d = RUN;
        RUN:     if (frame_end_c) state_d = FILL;
        default: state_d = FILL;
      endcase
    end else if (win_ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign win_o       = win_q;
  assign win_valid_o = valid_q;
  assign win_last_o  = last_q;

`ifdef GAUSS_WIN_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Windows accepted this frame; clears once the frame's last window is taken.
  always_comb begin
    cnt_d = cnt_q;
    if (win_acc_c) cnt_d = last_q ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign win_cnt_o = cnt_q;
`else
  logic unused_c;
  assign unused_c = win_acc_c;
`endif

endmodule

// File: tb/tb_gauss_window_gen.sv
// Self-checking bench for gauss_window_gen on a 5x4 image with a scoreboard model.
module tb_gauss_window_gen;

  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned WW = 9 * PW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [PW-1:0] pix_i = '0;
  logic          pix_valid_i = 1'b0;
  logic          pix_ready_o;
  logic [WW-1:0] win_o;
  logic          win_valid_o;
  logic          win_ready_i = 1'b0;
  logic          win_last_o;
`ifdef GAUSS_WIN_CNT_EN
  logic [16:0]   win_cnt_o;
  int            tcnt;
`endif

  always #5 clk_i = ~clk_i;

  gauss_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .win_o       (win_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i),
    .win_last_o  (win_last_o)
`ifdef GAUSS_WIN_CNT_EN
    ,
    .win_cnt_o   (win_cnt_o)
`endif
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          got_q[$];
  exp_t          tbl[6];
  logic [PW-1:0] img [H][W];
  int            trow, tcol;
  logic          exp_valid;
  logic          stall_prev;
  logic [WW-1:0] hold_win;
  int            n_chk, n_fail;

  function automatic logic [WW-1:0] pk(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
    int a[9];
    logic [WW-1:0] r;
    a = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
    r = '0;
    for (int k = 0; k < 9; k++) r[k*PW +: PW] = PW'(a[k]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock of stimulus plus scoreboard/model update; inputs change at negedge.
  task automatic step(input logic want, input logic rdy, input int off, output logic acc);
    exp_t e;
    @(negedge clk_i);
    chk("win_valid", WW'(win_valid_o), WW'(exp_valid));
    if (stall_prev) chk("win_hold", win_o, hold_win);
    win_ready_i = rdy;
    pix_valid_i = want;
    pix_i       = PW'((trow * W + tcol + off) % 256);
    #1;
    acc = pix_valid_i && pix_ready_o;
    if (win_valid_o && win_ready_i) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_window: got %h expected no window", win_o);
      end else begin
        e = sb_q.pop_front();
        chk("win_data", win_o, e.win);
        chk("win_last", WW'(win_last_o), WW'(e.last));
`ifdef GAUSS_WIN_CNT_EN
        chk("win_cnt", WW'(win_cnt_o), WW'(tcnt));
        tcnt = e.last ? 0 : tcnt + 1;
`endif
      end
      e.win  = win_o;
      e.last = win_last_o;
      got_q.push_back(e);
      exp_valid = 1'b0;
    end
    stall_prev = win_valid_o && !win_ready_i;
    hold_win   = win_o;
    if (acc) begin
      img[trow][tcol] = pix_i;
      exp_valid = (trow >= 2) && (tcol >= 2);
      if (exp_valid) begin
        for (int k = 0; k < 9; k++) e.win[k*PW +: PW] = img[trow-2+k/3][tcol-2+k%3];
        e.last = (trow == H - 1) && (tcol == W - 1);
        sb_q.push_back(e);
      end
      if (tcol == W - 1) begin
        tcol = 0;
        trow = (trow == H - 1) ? 0 : trow + 1;
      end else begin
        tcol++;
      end
    end
  endtask

  task automatic run_px(input int n, input int off, input int vpct, input int rpct);
    int   sent = 0;
    int   cyc  = 0;
    logic a;
    while (sent < n && cyc < 4000) begin
      step(($urandom_range(99) < vpct), ($urandom_range(99) < rpct), off, a);
      if (a) sent++;
      cyc++;
    end
    if (sent < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL pixel_timeout: got %0d accepted expected %0d", sent, n);
    end
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 0, a);
    chk("drain_empty", WW'(sb_q.size()), WW'(0));
`ifdef GAUSS_WIN_CNT_EN
    chk("cnt_after_frame", WW'(win_cnt_o), WW'(tcnt));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    pix_valid_i = 1'b0;
    win_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    sb_q.delete();
    trow       = 0;
    tcol       = 0;
    exp_valid  = 1'b0;
    stall_prev = 1'b0;
`ifdef GAUSS_WIN_CNT_EN
    tcnt = 0;
    chk("rst_cnt", WW'(win_cnt_o), WW'(0));
`endif
    #1;
    chk("rst_pix_ready", WW'(pix_ready_o), WW'(1));
    chk("rst_win_valid", WW'(win_valid_o), WW'(0));
    chk("rst_win_last", WW'(win_last_o), WW'(0));
    chk("rst_win", win_o, WW'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    tbl[0] = '{pk(0, 1, 2, 5, 6, 7, 10, 11, 12), 1'b0};
    tbl[1] = '{pk(1, 2, 3, 6, 7, 8, 11, 12, 13), 1'b0};
    tbl[2] = '{pk(2, 3, 4, 7, 8, 9, 12, 13, 14), 1'b0};
    tbl[3] = '{pk(5, 6, 7, 10, 11, 12, 15, 16, 17), 1'b0};
    tbl[4] = '{pk(6, 7, 8, 11, 12, 13, 16, 17, 18), 1'b0};
    tbl[5] = '{pk(7, 8, 9, 12, 13, 14, 17, 18, 19), 1'b1};

    do_reset();

    // Ramp frame, no stalls, checked against the hand table.
    got_q.delete();
    run_px(W * H, 0, 100, 100);
    drain();
    chk("ramp_count", WW'(got_q.size()), WW'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) begin
        chk("ramp_tbl_win", got_q[i].win, tbl[i].win);
        chk("ramp_tbl_last", WW'(got_q[i].last), WW'(tbl[i].last));
      end
    end

    // Back-to-back frames, second offset by 7.
    got_q.delete();
    run_px(W * H, 0, 100, 100);
    run_px(W * H, 7, 100, 100);
    drain();
    chk("seam_count", WW'(got_q.size()), WW'(12));
    if (got_q.size() > 6) chk("seam_first_win", got_q[6].win, pk(7, 8, 9, 12, 13, 14, 17, 18, 19));

    // Random input gaps and output stalls over ten frames.
    got_q.delete();
    run_px(10 * W * H, 0, 50, 50);
    drain();
    chk("rand_count", WW'(got_q.size()), WW'(60));
    for (int i = 0; i < got_q.size(); i++) chk("rand_vs_ramp", got_q[i].win, tbl[i % 6].win);

    // Reset after a partial frame, then a full frame with offset 3.
    run_px(13, 0, 100, 100);
    do_reset();
    got_q.delete();
    run_px(W * H, 3, 70, 60);
    drain();
    chk("post_rst_count", WW'(got_q.size()), WW'(6));
    if (got_q.size() > 0) chk("post_rst_first", got_q[0].win, pk(3, 4, 5, 8, 9, 10, 13, 14, 15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
